mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl_if.sv | 20 ++
 rtl/mem_access_ctrl.sv | 121 ++++++++++++
 tb/tb_mem_access_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// Data-memory bus between the MEM-stage access controller and the data memory.
// The controller is the master: it owns the request, the memory returns ack/data.
interface mem_access_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: turns a load/store in EX/MEM into a request/ack memory
// access, freezes the pipeline while it is outstanding, and aborts on timeout.
module mem_access_ctrl #(
    parameter logic [7:0] TIMEOUT = 8'd200
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      MemReadIN,
    input  logic                      MemWriteIN,
    input  logic [31:0]               ALU_IN,
    input  logic [31:0]               readData2IN,
    input  logic                      err_clr,
    mem_access_ctrl_if.master         mem,
    output logic                      stall,
    output logic                      bubble,
    output logic [31:0]               rdata_out,
    output logic                      rdata_valid,
    output logic                      bus_error
);

    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_e;

    localparam logic [7:0] LAST_CNT = TIMEOUT - 8'd1;

    state_e      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] rdata_out_q, rdata_out_d;
    logic        rdata_valid_q, rdata_valid_d;
    logic        bus_error_q, bus_error_d;
    logic [7:0]  cnt_q, cnt_d;

    logic access;
    logic illegal;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
        state_d     = state_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_out_d = rdata_out_q;
        cnt_d       = cnt_q;

        access  = MemReadIN | MemWriteIN;
        illegal = (MemReadIN & MemWriteIN) | (access & (ALU_IN[1:0] != 2'b00));

        unique case (state_q)
            IDLE: begin
                if (illegal) begin
                    state_d = ERR;
                end else if (access) begin
                    mem_addr_d  = ALU_IN;
                    mem_wdata_d = readData2IN;
                    mem_we_d    = MemWriteIN;
                    cnt_d       = 8'd0;
                    state_d     = REQ;
                end
            end
            REQ: begin
                // An ack on the final wait cycle still completes the access.
                if (mem.mem_ack) begin
                    rdata_out_d = mem_we_q ? 32'd0 : mem.mem_rdata;
                    state_d     = DONE;
                end else begin
                    if (cnt_q == LAST_CNT) state_d = ERR;
                    if (cnt_q != 8'hFF)    cnt_d   = cnt_q + 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_d == ERR) rdata_out_d = 32'd0;

        mem_req_d     = (state_d == REQ);
        rdata_valid_d = (state_d == DONE);
        // Entering or sitting in ERR overrides a simultaneous clear.
        bus_error_d   = (state_d == ERR) | (state_q == ERR) | (bus_error_q & ~err_clr);

        stall  = rst_n & (((state_q == IDLE) & access) | (state_q == REQ));
        bubble = stall;
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
        if (!rst_n) begin
            state_q       <= IDLE;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= 32'd0;
            mem_wdata_q   <= 32'd0;
            rdata_out_q   <= 32'd0;
            rdata_valid_q <= 1'b0;
            bus_error_q   <= 1'b0;
            cnt_q         <= 8'd0;
        end else begin
            state_q       <= state_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            rdata_out_q   <= rdata_out_d;
            rdata_valid_q <= rdata_valid_d;
            bus_error_q   <= bus_error_d;
            cnt_q         <= cnt_d;
        end
    end

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign rdata_out     = rdata_out_q;
    assign rdata_valid   = rdata_valid_q;
    assign bus_error     = bus_error_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl (TIMEOUT=4): per-cycle vector table plus a
// hand-written sequence for an ack arriving on the timeout cycle.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd, wr, err_clr;
    logic [31:0] alu_in, wdata_in;
    logic        stall, bubble, rdata_valid, bus_error;
    logic [31:0] rdata_out;

    int n_cmp = 0;
    int n_err = 0;

    mem_access_ctrl_if bus ();

    mem_access_ctrl #(.TIMEOUT(8'd4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .MemReadIN   (rd),
        .MemWriteIN  (wr),
        .ALU_IN      (alu_in),
        .readData2IN (wdata_in),
        .err_clr     (err_clr),
        .mem         (bus),
        .stall       (stall),
        .bubble      (bubble),
        .rdata_out   (rdata_out),
        .rdata_valid (rdata_valid),
        .bus_error   (bus_error)
    );

    always #5 clk = ~clk;

    // ctrl = {mem_req, mem_we, stall, bubble, rdata_valid, bus_error}
    typedef struct {
        logic        rst_n, rd, wr;
        logic [31:0] addr, wdata;
        logic        ack;
        logic [31:0] rdata;
        logic        clr;
        logic [5:0]  ctrl;
        logic [31:0] e_addr, e_wdata, e_rout;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic d, input logic w,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic ak, input logic [31:0] rdt, input logic c,
                                input logic [5:0] ctl, input logic [31:0] ea,
                                input logic [31:0] ew, input logic [31:0] er);
        vec_t v;
        v.rst_n = r; v.rd = d; v.wr = w; v.addr = a; v.wdata = wd;
        v.ack = ak; v.rdata = rdt; v.clr = c; v.ctrl = ctl;
        v.e_addr = ea; v.e_wdata = ew; v.e_rout = er;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] ctrl_now();
        return {bus.mem_req, bus.mem_we, stall, bubble, rdata_valid, bus_error};
    endfunction

    initial begin
        bool_dummy();
    end

    task automatic bool_dummy();
    endtask

    initial begin
        logic seen_req;

        rst_n = 1'b0; rd = 1'b0; wr = 1'b0; err_clr = 1'b0;
        alu_in = 32'd0; wdata_in = 32'd0;
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'd0;
        repeat (2) @(posedge clk);

        //                rst rd wr addr          wdata         ack rdata         clr ctrl       e_addr        e_wdata       e_rout
        // reset held with an access pending: stall must stay low
        vecs.push_back(mk(0, 1, 0, 32'h100,       32'h0,        0, 32'h0,         0, 6'b000000, 32'h0,        32'h0,        32'h0));
        // load 0x100, ack on third request cycle
        vecs.push_back(mk(1, 1, 0, 32'h100,       32'hAAAA0000, 0, 32'h0,         0, 6'b001100, 32'h0,        32'h0,        32'h0));
        vecs.push_back(mk(1, 1, 0, 32'h100,       32'hAAAA0000, 0, 32'h0,         0, 6'b101100, 32'h100,      32'hAAAA0000, 32'h0));
        vecs.push_back(mk(1, 1, 0, 32'h100,       32'hAAAA0000, 0, 32'h0,         0, 6'b101100, 32'h100,      32'hAAAA0000, 32'h0));
        vecs.push_back(mk(1, 1, 0, 32'h100,       32'hAAAA0000, 1, 32'hDEADBEEF,  0, 6'b101100, 32'h100,      32'hAAAA0000, 32'h0));
        vecs.push_back(mk(1, 1, 0, 32'h100,       32'hAAAA0000, 0, 32'h0,         0, 6'b000010, 32'h100,      32'hAAAA0000, 32'hDEADBEEF));
        // stray ack while idle is ignored
        vecs.push_back(mk(1, 0, 0, 32'h0,         32'h0,        1, 32'h11111111,  0, 6'b000000, 32'h100,      32'hAAAA0000, 32'hDEADBEEF));
        // store 0x40, ack on first request cycle
        vecs.push_back(mk(1, 0, 1, 32'h40,        32'h12345678, 0, 32'h0,         0, 6'b001100, 32'h100,      32'hAAAA0000, 32'hDEADBEEF));
        vecs.push_back(mk(1, 0, 1, 32'h40,        32'h12345678, 1, 32'h55555555,  0, 6'b111100, 32'h40,       32'h12345678, 32'hDEADBEEF));
        vecs.push_back(mk(1, 0, 1, 32'h40,        32'h12345678, 0, 32'h0,         0, 6'b010010, 32'h40,       32'h12345678, 32'h0));
        // misaligned load 0x102 -> ERR, then clear
        vecs.push_back(mk(1, 1, 0, 32'h102,       32'h0,        0, 32'h0,         0, 6'b011100, 32'h40,       32'h12345678, 32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h0,         32'h0,        0, 32'h0,         0, 6'b010001, 32'h40,       32'h12345678, 32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h0,         32'h0,        0, 32'h0,         1, 6'b010001, 32'h40,       32'h12345678, 32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h0,         32'h0,        0, 32'h0,         0, 6'b010000, 32'h40,       32'h12345678, 32'h0));
        // load 0x200 never acked -> four request cycles then ERR
        vecs.push_back(mk(1, 1, 0, 32'h200,       32'h0,        0, 32'h0,         0, 6'b011100, 32'h40,       32'h12345678, 32'h0));
        vecs.push_back(mk(1, 1, 0, 32'h200,       32'h0,        0, 32'h0,         0, 6'b101100, 32'h200,      32'h0,        32'h0));
        vecs.push_back(mk(1, 1, 0, 32'h200,       32'h0,        0, 32'h0,         0, 6'b101100, 32'h200,      32'h0,        32'h0));
        vecs.push_back(mk(1, 1, 0, 32'h200,       32'h0,        0, 32'h0,         0, 6'b101100, 32'h200,      32'h0,        32'h0));
        vecs.push_back(mk(1, 1, 0, 32'h200,       32'h0,        0, 32'h0,         0, 6'b101100, 32'h200,      32'h0,        32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h0,         32'h0,        0, 32'h0,         0, 6'b000001, 32'h200,      32'h0,        32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h0,         32'h0,        0, 32'h0,         1, 6'b000001, 32'h200,      32'h0,        32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h0,         32'h0,        0, 32'h0,         0, 6'b000000, 32'h200,      32'h0,        32'h0));
        // read+write together -> ERR; clear during ERR loses to the set
        vecs.push_back(mk(1, 1, 1, 32'h300,       32'h0,        0, 32'h0,         0, 6'b001100, 32'h200,      32'h0,        32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h0,         32'h0,        0, 32'h0,         1, 6'b000001, 32'h200,      32'h0,        32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h0,         32'h0,        0, 32'h0,         0, 6'b000001, 32'h200,      32'h0,        32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h0,         32'h0,        0, 32'h0,         1, 6'b000001, 32'h200,      32'h0,        32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h0,         32'h0,        0, 32'h0,         0, 6'b000000, 32'h200,      32'h0,        32'h0));
        // reset asserted mid-request, then a late ack
        vecs.push_back(mk(1, 1, 0, 32'h400,       32'hCAFEF00D, 0, 32'h0,         0, 6'b001100, 32'h200,      32'h0,        32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h400,       32'hCAFEF00D, 0, 32'h0,         0, 6'b100000, 32'h400,      32'hCAFEF00D, 32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h0,         32'h0,        1, 32'h99,        0, 6'b000000, 32'h0,        32'h0,        32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h0,         32'h0,        0, 32'h0,         0, 6'b000000, 32'h0,        32'h0,        32'h0));

        foreach (vecs[i]) begin
            @(negedge clk);
            rst_n = vecs[i].rst_n; rd = vecs[i].rd; wr = vecs[i].wr;
            alu_in = vecs[i].addr; wdata_in = vecs[i].wdata; err_clr = vecs[i].clr;
            bus.mem_ack = vecs[i].ack; bus.mem_rdata = vecs[i].rdata;
            #1;
            check($sformatf("v%0d_ctrl", i),  {26'd0, ctrl_now()}, {26'd0, vecs[i].ctrl});
            check($sformatf("v%0d_addr", i),  bus.mem_addr,  vecs[i].e_addr);
            check($sformatf("v%0d_wdata", i), bus.mem_wdata, vecs[i].e_wdata);
            check($sformatf("v%0d_rdata", i), rdata_out,     vecs[i].e_rout);
        end

        // Ack on the timeout cycle (4th request cycle) must complete, not error.
        @(negedge clk);
        rst_n = 1'b1; rd = 1'b1; wr = 1'b0; alu_in = 32'h500; wdata_in = 32'h0;
        err_clr = 1'b0; bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
        seen_req = 1'b0;
        for (int t = 0; t < 10 && !seen_req; t++) begin
            @(negedge clk);
            seen_req = bus.mem_req;
        end
        check("to_req_seen", {31'd0, seen_req}, 32'd1);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("to_req_c%0d", i), {31'd0, bus.mem_req}, 32'd1);
            bus.mem_ack   = (i == 4);
            bus.mem_rdata = (i == 4) ? 32'h0BADF00D : 32'h0;
            @(negedge clk);
        end
        bus.mem_ack = 1'b0;
        #1;
        check("to_done_valid", {31'd0, rdata_valid}, 32'd1);
        check("to_done_rdata", rdata_out, 32'h0BADF00D);
        check("to_done_berr",  {31'd0, bus_error}, 32'd0);
        check("to_done_stall", {31'd0, stall}, 32'd0);
        rd = 1'b0;
        @(negedge clk);
        #1;
        check("to_idle_valid", {31'd0, rdata_valid}, 32'd0);
        check("to_idle_berr",  {31'd0, bus_error}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
